intersection_scheduler: RTL and testbench

Two-road (north-south / east-west) phase scheduler for the DE10-Lite traffic controller. It sequences green, yellow and all-red clearance phases for both roads from one shared second-based timer, and grants per-crosswalk pedestrian requests. It also runs a flashing night mode. It sits between the debounced button / switch inputs and the LED / seven-segment mapping, and replaces the per-phase timer instances with one scheduler-owned countdown.

---
 rtl/intersection_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_intersection_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Two-road phase scheduler: green/yellow/all-red sequencing from one shared second timer,
// per-crosswalk walk grants and a flashing night mode.
module intersection_scheduler #(
    parameter int unsigned TICKS_1S = 50_000_000,
    parameter int unsigned WALK_S   = 7,
    parameter int unsigned ALLRED_S = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       night_mode,
    input  logic       low_mode,
    input  logic       high_mode,
    input  logic       ped_ns_pulse,
    input  logic       ped_ew_pulse,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [1:0] ped_pending,
    output logic [3:0] sec_left,
    output logic [2:0] phase
);

    localparam int unsigned TickW     = (TICKS_1S > 1) ? $clog2(TICKS_1S) : 1;
    localparam int unsigned HalfTicks = (TICKS_1S >= 2) ? TICKS_1S / 2 : 1;

    localparam logic [TickW-1:0] TickLast  = TickW'(TICKS_1S - 1);
    localparam logic [TickW-1:0] HalfLast  = TickW'(HalfTicks - 1);
    localparam logic [3:0]       WalkSec   = 4'(WALK_S);
    localparam logic [3:0]       AllRedSec = 4'(ALLRED_S);

    localparam logic [2:0] LightRed    = 3'b100;
    localparam logic [2:0] LightYellow = 3'b010;
    localparam logic [2:0] LightGreen  = 3'b001;
    localparam logic [2:0] LightOff    = 3'b000;

    typedef enum logic [2:0] {
        StNsGreen  = 3'd0,
        StNsYellow = 3'd1,
        StAllRedA  = 3'd2,
        StEwGreen  = 3'd3,
        StEwYellow = 3'd4,
        StAllRedB  = 3'd5,
        StNight    = 3'd6
    } state_e;

    function automatic logic [3:0] green_secs(input logic hi, input logic lo, input logic walk);
        logic [3:0] secs;
        if (hi) begin
            secs = 4'd10;
        end else if (lo) begin
            secs = 4'd5;
        end else begin
            secs = 4'd7;
        end
        if (walk && (WalkSec > secs)) begin
            secs = WalkSec;
        end
        return secs;
    endfunction

    function automatic logic [3:0] yellow_secs(input logic hi, input logic lo);
        return (lo && !hi) ? 4'd2 : 4'd3;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         sec_q, sec_d, sec_cur;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [1:0]         ped_q, ped_d, ped_req;
    logic               walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic [3:0]         walk_sec_q, walk_sec_d;
    logic               flash_q, flash_d;
    logic               init_q;
    logic [2:0]         ns_q, ns_d, ew_q, ew_d;
    logic               wrap, expire;

    // The first green after reset takes its length from the mode inputs seen on that cycle.
    assign sec_cur = init_q ? green_secs(high_mode, low_mode, 1'b0) : sec_q;
    assign wrap    = (tick_q == TickLast);
    assign expire  = wrap && (sec_cur == 4'd1);
    assign ped_req = ped_q | {ped_ew_pulse, ped_ns_pulse};

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_cur;
        tick_d     = tick_q;
        ped_d      = ped_q;
        walk_ns_d  = walk_ns_q;
        walk_ew_d  = walk_ew_q;
        walk_sec_d = walk_sec_q;
        flash_d    = flash_q;

        if (state_q == StNight) begin
            sec_d = 4'd0;
            if (!night_mode) begin
                state_d = StAllRedB;
                sec_d   = AllRedSec;
                tick_d  = '0;
            end else if (tick_q == HalfLast) begin
                tick_d  = '0;
                flash_d = ~flash_q;
            end else begin
                tick_d = tick_q + TickW'(1);
            end
        end else begin
            ped_d  = ped_req;
            tick_d = wrap ? '0 : tick_q + TickW'(1);
            if (wrap) begin
                sec_d = sec_cur - 4'd1;
            end
            if (wrap && (walk_ns_q || walk_ew_q)) begin
                walk_sec_d = walk_sec_q - 4'd1;
                if (walk_sec_q == 4'd1) begin
                    walk_ns_d = 1'b0;
                    walk_ew_d = 1'b0;
                end
            end

            if (expire) begin
                case (state_q)
                    StNsGreen: begin
                        state_d   = StNsYellow;
                        sec_d     = yellow_secs(high_mode, low_mode);
                        walk_ns_d = 1'b0;
                    end
                    StNsYellow: begin
                        state_d = StAllRedA;
                        sec_d   = AllRedSec;
                    end
                    StEwGreen: begin
                        state_d   = StEwYellow;
                        sec_d     = yellow_secs(high_mode, low_mode);
                        walk_ew_d = 1'b0;
                    end
                    StEwYellow: begin
                        state_d = StAllRedB;
                        sec_d   = AllRedSec;
                    end
                    StAllRedA, StAllRedB: begin
                        if (night_mode) begin
                            state_d = StNight;
                            sec_d   = 4'd0;
                            flash_d = 1'b1;
                        end else if (state_q == StAllRedA) begin
                            state_d    = StEwGreen;
                            sec_d      = green_secs(high_mode, low_mode, ped_req[1]);
                            walk_ew_d  = ped_req[1];
                            walk_sec_d = WalkSec;
                            ped_d[1]   = 1'b0;
                        end else begin
                            state_d    = StNsGreen;
                            sec_d      = green_secs(high_mode, low_mode, ped_req[0]);
                            walk_ns_d  = ped_req[0];
                            walk_sec_d = WalkSec;
                            ped_d[0]   = 1'b0;
                        end
                    end
                    default: state_d = StNsGreen;
                endcase
            end
        end

        // Lights are decoded from the next state so they change on the same edge as phase.
        case (state_d)
            StNsGreen:  begin ns_d = LightGreen;  ew_d = LightRed;    end
            StNsYellow: begin ns_d = LightYellow; ew_d = LightRed;    end
            StEwGreen:  begin ns_d = LightRed;    ew_d = LightGreen;  end
            StEwYellow: begin ns_d = LightRed;    ew_d = LightYellow; end
            StNight: begin
                ns_d = flash_d ? LightYellow : LightOff;
                ew_d = flash_d ? LightRed : LightOff;
            end
            default:    begin ns_d = LightRed;    ew_d = LightRed;    end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StNsGreen;
            sec_q      <= 4'd7;
            tick_q     <= '0;
            ped_q      <= 2'b00;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            walk_sec_q <= 4'd0;
            flash_q    <= 1'b1;
            init_q     <= 1'b1;
            ns_q       <= LightGreen;
            ew_q       <= LightRed;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            tick_q     <= tick_d;
            ped_q      <= ped_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            walk_sec_q <= walk_sec_d;
            flash_q    <= flash_d;
            init_q     <= 1'b0;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
        end
    end

    assign phase       = state_q;
    assign sec_left    = sec_cur;
    assign ns_light    = ns_q;
    assign ew_light    = ew_q;
    assign walk_ns     = walk_ns_q;
    assign walk_ew     = walk_ew_q;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: dwell table, directed corner sequences and a randomized
// run, all checked every cycle against a cycle-countdown reference model.
module tb_intersection_scheduler;

    localparam int T      = 4;
    localparam int WALK   = 7;
    localparam int ALLRED = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       night_mode = 1'b0, low_mode = 1'b0, high_mode = 1'b0;
    logic       ped_ns_pulse = 1'b0, ped_ew_pulse = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk_ns, walk_ew;
    logic [1:0] ped_pending;
    logic [3:0] sec_left;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .TICKS_1S(T),
        .WALK_S  (WALK),
        .ALLRED_S(ALLRED)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .night_mode  (night_mode),
        .low_mode    (low_mode),
        .high_mode   (high_mode),
        .ped_ns_pulse(ped_ns_pulse),
        .ped_ew_pulse(ped_ew_pulse),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk_ns     (walk_ns),
        .walk_ew     (walk_ew),
        .ped_pending (ped_pending),
        .sec_left    (sec_left),
        .phase       (phase)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each phase is a countdown of remaining cycles; seconds derived by division.
    typedef struct packed {
        int         ph;
        int         left;
        int         walk;
        int         ncnt;
        logic [1:0] pend;
        bit         init;
    } model_t;

    model_t m;

    function automatic int green_s(bit hi, bit lo, bit grant);
        int s;
        s = hi ? 10 : (lo ? 5 : 7);
        if (grant && WALK > s) s = WALK;
        return s;
    endfunction

    function automatic int yellow_s(bit hi, bit lo);
        return hi ? 3 : (lo ? 2 : 3);
    endfunction

    function automatic model_t model_reset(bit hi, bit lo);
        model_t r;
        r.ph = 0; r.left = green_s(hi, lo, 1'b0) * T; r.walk = 0; r.ncnt = 0;
        r.pend = 2'b00; r.init = 1'b1;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, bit hi, bit lo, bit night, bit pns, bit pew);
        model_t     n;
        logic [1:0] req;
        int         road;
        bit         grant;
        n = cur;
        if (n.init) begin
            n.left = green_s(hi, lo, 1'b0) * T;
            n.init = 1'b0;
        end
        if (n.ph == 6) begin
            if (!night) begin
                n.ph = 5; n.left = ALLRED * T;
            end else begin
                n.ncnt++;
            end
            return n;
        end
        req = n.pend | {pew, pns};
        n.pend = req;
        if (n.walk > 0) n.walk--;
        n.left--;
        if (n.left == 0) begin
            case (n.ph)
                0, 3: begin n.ph = n.ph + 1; n.left = yellow_s(hi, lo) * T; n.walk = 0; end
                1, 4: begin n.ph = n.ph + 1; n.left = ALLRED * T; end
                default: begin
                    if (night) begin
                        n.ph = 6; n.ncnt = 0;
                    end else begin
                        road   = (n.ph == 2) ? 1 : 0;
                        n.ph   = (n.ph == 2) ? 3 : 0;
                        grant  = req[road];
                        n.left = green_s(hi, lo, grant) * T;
                        n.walk = grant ? WALK * T : 0;
                        n.pend[road] = 1'b0;
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic [16:0] expect_out(model_t cur, bit hi, bit lo);
        logic [2:0] ns, ew;
        bit         on;
        int         sec;
        case (cur.ph)
            0: begin ns = 3'b001; ew = 3'b100; end
            1: begin ns = 3'b010; ew = 3'b100; end
            3: begin ns = 3'b100; ew = 3'b001; end
            4: begin ns = 3'b100; ew = 3'b010; end
            6: begin
                on = ((cur.ncnt / 2) % 2) == 0;
                ns = on ? 3'b010 : 3'b000;
                ew = on ? 3'b100 : 3'b000;
            end
            default: begin ns = 3'b100; ew = 3'b100; end
        endcase
        if (cur.ph == 6) sec = 0;
        else if (cur.init) sec = green_s(hi, lo, 1'b0);
        else sec = (cur.left + T - 1) / T;
        return {3'(cur.ph), ns, ew, (cur.ph == 0 && cur.walk > 0), (cur.ph == 3 && cur.walk > 0),
                cur.pend, 4'(sec)};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset(high_mode, low_mode);
        else m <= model_next(m, high_mode, low_mode, night_mode, ped_ns_pulse, ped_ew_pulse);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", {phase, ns_light, ew_light, walk_ns, walk_ew, ped_pending, sec_left},
                  expect_out(m, high_mode, low_mode));
            check("both_green", ns_light[0] & ew_light[0], 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit hi, input bit lo);
        high_mode = hi; low_mode = lo; night_mode = 1'b0;
        ped_ns_pulse = 1'b0; ped_ew_pulse = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_phase(input logic [2:0] ph);
        int guard = 0;
        while (phase !== ph && guard < 300) begin
            step();
            guard++;
        end
        check("wait_phase", phase, ph);
    endtask

    task automatic measure(input logic [2:0] ph, output int dwell);
        int guard = 0;
        dwell = 0;
        while (phase !== ph && guard < 300) begin
            step();
            guard++;
        end
        while (phase === ph && dwell < 300) begin
            dwell++;
            step();
        end
    endtask

    typedef struct packed {
        bit         rst;
        bit         hi;
        bit         lo;
        logic [2:0] ph;
        int         dwell;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(bit rst, bit hi, bit lo, int ph, int dwell);
        vec_t v;
        v.rst = rst; v.hi = hi; v.lo = lo; v.ph = 3'(ph); v.dwell = dwell;
        return v;
    endfunction

    initial begin
        int d, wcnt;

        vecs[0]  = mk(1, 0, 0, 0, 28);
        vecs[1]  = mk(0, 0, 0, 1, 12);
        vecs[2]  = mk(0, 0, 0, 2, 4);
        vecs[3]  = mk(0, 0, 0, 3, 28);
        vecs[4]  = mk(0, 0, 0, 4, 12);
        vecs[5]  = mk(0, 0, 0, 5, 4);
        vecs[6]  = mk(0, 0, 0, 0, 28);
        vecs[7]  = mk(1, 1, 0, 0, 40);
        vecs[8]  = mk(0, 1, 0, 1, 12);
        vecs[9]  = mk(0, 1, 0, 2, 4);
        vecs[10] = mk(0, 1, 0, 3, 40);
        vecs[11] = mk(1, 0, 1, 0, 20);
        vecs[12] = mk(0, 0, 1, 1, 8);
        vecs[13] = mk(0, 0, 1, 2, 4);
        vecs[14] = mk(0, 0, 1, 3, 20);

        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();

        do_reset(1'b0, 1'b0);
        chk_en = 1'b1;
        check("rst_phase", phase, 0);
        check("rst_lights", {ns_light, ew_light}, 6'b001_100);
        check("rst_sec", sec_left, 7);
        check("rst_walk_pend", {walk_ns, walk_ew, ped_pending}, 0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst) do_reset(vecs[i].hi, vecs[i].lo);
            measure(vecs[i].ph, d);
            check($sformatf("dwell[%0d]", i), d, vecs[i].dwell);
        end

        // High mode from reset, switch to low mid-green.
        do_reset(1'b1, 1'b0);
        repeat (10) step();
        high_mode = 1'b0; low_mode = 1'b1;
        measure(3'd0, d);
        check("hi_green_kept", d + 10, 40);
        measure(3'd1, d);
        check("lo_yellow", d, 8);
        measure(3'd3, d);
        check("lo_ew_green", d, 20);

        // NS request during EW green in low mode: grant extends green to walk length.
        do_reset(1'b0, 1'b1);
        wait_phase(3'd3);
        repeat (2) step();
        ped_ns_pulse = 1'b1; step(); ped_ns_pulse = 1'b0;
        check("ns_pending", ped_pending, 2'b01);
        wait_phase(3'd0);
        check("ns_granted_pend", ped_pending, 2'b00);
        d = 0; wcnt = 0;
        while (phase === 3'd0 && d < 300) begin
            if (walk_ns === 1'b1) wcnt++;
            d++;
            step();
        end
        check("ns_walk_len", wcnt, 28);
        check("ns_ext_green", d, 28);

        // EW pulse on the entry cycle is granted; a pulse during the walk is left pending.
        do_reset(1'b0, 1'b0);
        wait_phase(3'd2);
        repeat (3) step();
        ped_ew_pulse = 1'b1; step(); ped_ew_pulse = 1'b0;
        check("ew_entry_phase", phase, 3);
        check("ew_entry_walk", {walk_ew, ped_pending}, 3'b1_00);
        repeat (5) step();
        ped_ew_pulse = 1'b1; step(); ped_ew_pulse = 1'b0;
        check("ew_during_walk", {walk_ew, ped_pending}, 3'b1_10);
        wait_phase(3'd0);
        wait_phase(3'd3);
        check("ew_next_round", {walk_ew, ped_pending}, 3'b1_00);

        // Night mode entry after the all-red, flashing, exit via ALL_RED_B.
        do_reset(1'b0, 1'b0);
        repeat (5) step();
        night_mode = 1'b1;
        measure(3'd0, d);
        check("night_ns_green", d + 5, 28);
        measure(3'd1, d);
        measure(3'd2, d);
        check("night_allred_a", d, 4);
        check("night_phase", phase, 6);
        check("night_sec", sec_left, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("night_flash[%0d]", k), {ns_light, ew_light},
                  ((k / 2) % 2 == 0) ? 6'b010_100 : 6'b000_000);
            ped_ns_pulse = (k == 3); ped_ew_pulse = (k == 3);
            step();
        end
        ped_ns_pulse = 1'b0; ped_ew_pulse = 1'b0;
        check("night_pend", ped_pending, 2'b00);
        night_mode = 1'b0;
        step();
        measure(3'd5, d);
        check("night_exit_allred", d, 4);
        check("night_exit_green", {phase, sec_left}, {3'd0, 4'd7});

        // Asynchronous reset mid EW yellow with both requests pending.
        do_reset(1'b0, 1'b0);
        wait_phase(3'd3);
        step();
        ped_ns_pulse = 1'b1; ped_ew_pulse = 1'b1; step();
        ped_ns_pulse = 1'b0; ped_ew_pulse = 1'b0;
        wait_phase(3'd4);
        repeat (2) step();
        check("pre_reset_pend", ped_pending, 2'b11);
        reset_n = 1'b0;
        #1;
        check("async_rst", {phase, ns_light, ew_light, walk_ns, walk_ew, ped_pending, sec_left},
              {3'd0, 3'b001, 3'b100, 1'b0, 1'b0, 2'b00, 4'd7});
        step();
        reset_n = 1'b1;

        // Randomized run; the per-cycle model comparison does the checking.
        for (int c = 0; c < 4000; c++) begin
            ped_ns_pulse = ($urandom_range(0, 19) == 0);
            ped_ew_pulse = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                high_mode = $urandom_range(0, 1) == 1;
                low_mode  = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 299) == 0) night_mode = ~night_mode;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
